// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM status codes, arbiter states and the machine word.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Encoding is fixed by the RAM model's status port.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating streak counter: counts consecutive dcache grants taken while icache waits.
// Latency: at_limit reflects the count registered on the previous edge.
// Backpressure: none; inc and clr are single-cycle strobes, clr has priority.
//
// Ports: CLK/RST clock and async active-high reset, inc/clr strobes,
//        at_limit high once the count has reached LIMIT.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between icache and dcache; dcache wins unless icache is starved.
// Latency: 2 cycles minimum (grant edge, then the RAM ACCESS cycle); one IDLE cycle between transactions.
// Backpressure: requesters hold request/address while their wait is high; wait drops for the completion cycle only.
//
// Ports: CLK/RST clock and async active-high reset; iREN/iaddr -> iwait/iload icache side;
//        dREN/dWEN/daddr/dstore -> dwait/dload dcache side; ramREN/ramWEN/ramaddr/ramstore/
//        ramload/ramstate RAM side. Defining MEM_ARBITER_STATS_EN adds i_grants, d_grants
//        and i_stall_cycles (32-bit wrapping counters).
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output word_t             i_grants,
    output word_t             d_grants,
    output word_t             i_stall_cycles
`endif
);

    arb_state_t        state;
    arb_state_t        next_state;
    ramstate_t         rs;
    logic              dreq;
    logic              grant_d;
    logic              grant_i;
    logic              starved;
    logic              i_done;
    logic              d_done;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] store_q;
    logic              wr_q;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and grant decisions. ERROR drops back to IDLE so the
    // still-held request is simply re-arbitrated.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                if (dreq && !(iREN && starved)) begin
                    next_state = GNT_D;
                    grant_d    = 1'b1;
                end else if (iREN) begin
                    next_state = GNT_I;
                    grant_i    = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if ((rs == ACCESS) || (rs == ERROR)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture at grant time; RAM-side signals come only from these.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= daddr;
            store_q <= dstore;
            wr_q    <= dWEN;
        end else if (grant_i) begin
            addr_q  <= iaddr;
            wr_q    <= 1'b0;
        end
    end

    // Streak only grows while icache is actually waiting behind dcache.
    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .CLK      (CLK),
        .RST      (RST),
        .inc      (grant_d & iREN),
        .clr      ((grant_d & ~iREN) | grant_i),
        .at_limit (starved)
    );

    assign i_done = (state == GNT_I) && (rs == ACCESS);
    assign d_done = (state == GNT_D) && (rs == ACCESS);

    // Output decode.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = ~i_done;
        dwait    = ~d_done;
        iload    = '0;
        dload    = '0;
        case (state)
            GNT_I: begin
                ramREN  = 1'b1;
                ramaddr = addr_q;
                if (i_done) begin
                    iload = ramload;
                end
            end
            GNT_D: begin
                ramREN   = ~wr_q;
                ramWEN   = wr_q;
                ramaddr  = addr_q;
                ramstore = store_q;
                if (d_done && !wr_q) begin
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_grants       <= '0;
            d_grants       <= '0;
            i_stall_cycles <= '0;
        end else begin
            if (i_done) begin
                i_grants <= i_grants + 1'b1;
            end
            if (d_done) begin
                d_grants <= d_grants + 1'b1;
            end
            if (iREN && iwait) begin
                i_stall_cycles <= i_stall_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard for both cache sides.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] i_grants;
    logic [31:0] d_grants;
    logic [31:0] i_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int i_done = 0;
    int d_done = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
`ifdef MEM_ARBITER_STATS_EN
        ,
        .i_grants       (i_grants),
        .d_grants       (d_grants),
        .i_stall_cycles (i_stall_cycles)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: any completion pulse must match the oldest expected result.
    task automatic monitor();
        logic [31:0] e;
        if (iwait === 1'b0) begin
            i_done++;
            if (iq.size() == 0) begin
                chk("i_pulse_unexpected", {31'b0, iwait}, 32'd1);
            end else begin
                e = iq.pop_front();
                chk("iload", iload, e);
            end
        end else begin
            chk("iload_idle", iload, 32'd0);
        end
        if (dwait === 1'b0) begin
            d_done++;
            if (dq.size() == 0) begin
                chk("d_pulse_unexpected", {31'b0, dwait}, 32'd1);
            end else begin
                e = dq.pop_front();
                chk("dload", dload, e);
            end
        end else begin
            chk("dload_idle", dload, 32'd0);
        end
    endtask

    task automatic sample();
        @(negedge CLK);
        monitor();
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = R_FREE;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'b0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        next();
        RST = 1'b0;

        // Single fetch: two BUSY cycles then ACCESS.
        iREN = 1'b1; iaddr = 32'h100; ramstate = R_BUSY; ramload = 32'hDEADBEEF;
        iq.push_back(32'hDEADBEEF);
        sample(); chk("fetch_idle_ren", {31'b0, ramREN}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            next(); sample();
            chk("fetch_busy_ren", {31'b0, ramREN}, 32'd1);
            chk("fetch_busy_addr", ramaddr, 32'h100);
            chk("fetch_busy_iwait", {31'b0, iwait}, 32'd1);
        end
        next(); ramstate = R_ACCESS; sample();
        chk("fetch_acc_ren", {31'b0, ramREN}, 32'd1);
        chk("fetch_done", i_done, 32'd1);
        next(); iREN = 1'b0; ramstate = R_FREE; sample();
        chk("fetch_gap_ren", {31'b0, ramREN}, 32'd0);

        // Priority: simultaneous icache read and dcache write.
        iREN = 1'b1; iaddr = 32'h300; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234;
        ramstate = R_ACCESS; ramload = 32'hAAAA5555;
        dq.push_back(32'h0);
        iq.push_back(32'hAAAA5555);
        next(); sample();
        chk("prio_wen", {31'b0, ramWEN}, 32'd1);
        chk("prio_ren", {31'b0, ramREN}, 32'd0);
        chk("prio_addr", ramaddr, 32'h200);
        chk("prio_store", ramstore, 32'h1234);
        chk("prio_d_first", i_done, 32'd1);
        next(); dWEN = 1'b0; sample();
        chk("prio_gap_wen", {31'b0, ramWEN}, 32'd0);
        chk("prio_gap_ren", {31'b0, ramREN}, 32'd0);
        next(); sample();
        chk("prio_i_ren", {31'b0, ramREN}, 32'd1);
        chk("prio_i_addr", ramaddr, 32'h300);
        chk("prio_i_done", i_done, 32'd2);
        next(); iREN = 1'b0;
        sample();

        // Starvation: both sides held, RAM answers every cycle.
        iREN = 1'b1; iaddr = 32'h400; dREN = 1'b1; daddr = 32'h500; ramload = 32'hCAFE0000;
        for (int k = 0; k < 4; k++) dq.push_back(32'hCAFE0000);
        iq.push_back(32'hCAFE0000);
        dq.push_back(32'hCAFE0000);
        for (int k = 0; k < 4; k++) begin
            next(); sample();
            chk("starve_d_ren", {31'b0, ramREN}, 32'd1);
            chk("starve_d_addr", ramaddr, 32'h500);
            next(); sample();
            chk("starve_gap", {31'b0, ramREN}, 32'd0);
        end
        chk("starve_d_count", d_done, 32'd5);
        next(); sample();
        chk("starve_i_addr", ramaddr, 32'h400);
        chk("starve_i_done", i_done, 32'd3);
        next(); sample();
        next(); sample();
        chk("starve_resume_addr", ramaddr, 32'h500);
        chk("starve_resume_done", d_done, 32'd6);
        next(); iREN = 1'b0; dREN = 1'b0;
        sample();

        // ERROR during GNT_I: no pulse, back to IDLE, re-grant, then complete.
        iREN = 1'b1; iaddr = 32'h600; ramstate = R_ERROR; ramload = 32'h0BADF00D;
        iq.push_back(32'h0BADF00D);
        next(); sample();
        chk("err_ren", {31'b0, ramREN}, 32'd1);
        chk("err_no_pulse", {31'b0, iwait}, 32'd1);
        next(); ramstate = R_ACCESS; sample();
        chk("err_idle_ren", {31'b0, ramREN}, 32'd0);
        next(); sample();
        chk("err_regrant_addr", ramaddr, 32'h600);
        chk("err_done", i_done, 32'd4);
        next(); iREN = 1'b0;
        sample();

        // dREN and dWEN together: write wins, dload stays 0.
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h700; dstore = 32'h5A5A5A5A; ramload = 32'hFFFFFFFF;
        dq.push_back(32'h0);
        next(); sample();
        chk("both_wen", {31'b0, ramWEN}, 32'd1);
        chk("both_ren", {31'b0, ramREN}, 32'd0);
        chk("both_store", ramstore, 32'h5A5A5A5A);
        chk("both_done", d_done, 32'd7);
        next(); dREN = 1'b0; dWEN = 1'b0;
        sample();

        // Reset in the middle of a BUSY dcache write.
        dWEN = 1'b1; daddr = 32'h800; dstore = 32'h77; ramstate = R_BUSY;
        next(); sample();
        chk("mid_wen", {31'b0, ramWEN}, 32'd1);
        RST = 1'b1;
        #1;
        chk("mid_rst_wen", {31'b0, ramWEN}, 32'd0);
        chk("mid_rst_addr", ramaddr, 32'd0);
        chk("mid_rst_store", ramstore, 32'd0);
        chk("mid_rst_dwait", {31'b0, dwait}, 32'd1);
        next(); sample();
        chk("mid_rst_hold_wen", {31'b0, ramWEN}, 32'd0);
        RST = 1'b0; dWEN = 1'b0; ramstate = R_ACCESS;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("post_rst_wen", {31'b0, ramWEN}, 32'd0);
            next();
        end
        chk("post_rst_no_dpulse", d_done, 32'd7);

        chk("iq_drained", iq.size(), 32'd0);
        chk("dq_drained", dq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
